bbus_master: RTL and testbench
==============================

# bbus_master

Active SNES B-bus (PPU bus) cycle generator; drop-in replacement for the idle B-bus stub on the same pin-side ports. Accepts single read/write requests from the on-FPGA command logic through a valid/ready handshake and sequences PA/PD, PARD_n/PAWR_n and the level-shifter/FPGA direction controls with a bus-safe turnaround order. Reads return the sampled PD byte on a one-cycle response strobe.

## Interface
Parameters:
- SETUP_CYCLES, default 1: cycles address/data are stable before the strobe falls (≥1).
- STROBE_CYCLES, default 2: cycles PARD_n/PAWR_n are held low (≥1).
- HOLD_CYCLES, default 1: cycles address/data are held after the strobe rises (≥1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; high only in IDLE.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  8  B-bus address ($21xx low byte).
- req_data  in  8  write data (ignored for reads).
- rsp_valid  out  1  one-cycle pulse at transaction end (reads and writes).
- rsp_data  out  8  read byte; 0x00 for writes; valid with rsp_valid.
- pard_n  out  1  B-bus read strobe, active low.
- pawr_n  out  1  B-bus write strobe, active low.
- lvl_pa_dir  out  1  PA level-shifter direction.
- pa_in  in  8  PA pins input (unused; kept for port compatibility).
- pa_out  out  8  PA drive value.
- pa_dir  out  1  PA FPGA pin direction.
- lvl_pd_dir  out  1  PD level-shifter direction.
- pd_in  in  8  PD pins input.
- pd_out  out  8  PD drive value.
- pd_dir  out  1  PD FPGA pin direction.

## Operation
- Idle/reset values (all outputs registered except req_ready): pard_n=1, pawr_n=1, lvl_pa_dir=lvl_pd_dir=LVL_DIR_INPUT, pa_dir=pd_dir=DIR_INPUT, pa_out=pd_out=0x00, rsp_valid=0, rsp_data=0x00.
- Handshake: accept when req_valid && req_ready; addr/data/write latched on that edge. req_ready = (state == IDLE).
- States: IDLE → TURN_ON (1) → SETUP (SETUP_CYCLES) → STROBE (STROBE_CYCLES) → HOLD (HOLD_CYCLES) → TURN_OFF (1) → IDLE. One down-counter, width sized to max parameter, reloaded on each state entry.
- TURN_ON: lvl_pa_dir=LVL_DIR_OUTPUT; lvl_pd_dir=LVL_DIR_OUTPUT for writes only; FPGA dirs still input; pa_out/pd_out loaded.
- SETUP/STROBE/HOLD: pa_dir=DIR_OUTPUT; pd_dir=DIR_OUTPUT for writes, DIR_INPUT for reads; pa_out/pd_out stable.
- STROBE: pawr_n=0 (write) or pard_n=0 (read); exactly one strobe low per transaction.
- Read sample: pd_in captured on the clock edge ending the last STROBE cycle (pard_n still low).
- TURN_OFF: FPGA dirs return to DIR_INPUT; level shifters still output. IDLE entry: level shifters to LVL_DIR_INPUT, pa_out/pd_out to 0x00.
- Ordering invariant: FPGA pin never drives while its level shifter points input; level shifter never points output toward FPGA while FPGA drives.
- rsp_valid pulses for the one cycle the block is in TURN_OFF.
- rst mid-transaction: next cycle all outputs at idle values, no rsp_valid, state IDLE.

## Timing
- Accept at edge 0; strobe falls on edge 1+SETUP_CYCLES; rises STROBE_CYCLES later; rsp_valid high in cycle 2+SETUP+STROBE+HOLD.
- Defaults: 7 cycles accept-to-next-accept, rsp_valid in cycle 6 after accept.
- Back-to-back: req_valid held high → next accept on the first IDLE cycle; no strobe overlap.

## Structure
- Shared package bbus_defs: DIR_INPUT, DIR_OUTPUT, LVL_DIR_INPUT, LVL_DIR_OUTPUT, state encoding.
- Single module, no sub-modules; counter inline.

## Test plan
- Write, defaults, addr 0x18 data 0x5A → pawr_n low exactly 2 cycles, pa_out=0x18, pd_out=0x5A stable from SETUP through HOLD, pard_n never low, rsp_valid in cycle 6, rsp_data 0x00.
- Read addr 0x3F, pd_in=0xA5 during strobe (0xFF elsewhere) → pard_n low 2 cycles, pd_dir=DIR_INPUT throughout, rsp_data=0xA5.
- Direction ordering: every cycle check invariant; lvl_*_dir changes one cycle before/after pa_dir/pd_dir.
- Back-to-back write then read with req_valid held → req_ready low 7 cycles, second accept on first IDLE cycle, two rsp_valid pulses 7 cycles apart.
- rst asserted during STROBE → next cycle pawr_n=1, all dirs input, outs 0x00, no rsp_valid.
- SETUP=3, STROBE=4, HOLD=2 → strobe low 4 cycles, rsp_valid in cycle 11.

Source files
------------

// File: rtl/bbus_defs.sv
// SNES B-bus master shared definitions.
// Pin direction encodings and FSM state encoding.
package bbus_defs;

  localparam logic DIR_INPUT      = 1'b0;
  localparam logic DIR_OUTPUT     = 1'b1;
  localparam logic LVL_DIR_INPUT  = 1'b0;
  localparam logic LVL_DIR_OUTPUT = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_TURN_ON  = 3'd1,
    ST_SETUP    = 3'd2,
    ST_STROBE   = 3'd3,
    ST_HOLD     = 3'd4,
    ST_TURN_OFF = 3'd5
  } state_t;

endpackage

// File: rtl/bbus_master.sv
// SNES B-bus (PPU bus) cycle generator: one read/write per request.
// Ports: clk/rst; req_* handshake in; rsp_* out; pa/pd pin-side controls.
module bbus_master
  import bbus_defs::*;
#(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       pard_n,
  output logic       pawr_n,
  output logic       lvl_pa_dir,
  input  logic [7:0] pa_in,
  output logic [7:0] pa_out,
  output logic       pa_dir,
  output logic       lvl_pd_dir,
  input  logic [7:0] pd_in,
  output logic [7:0] pd_out,
  output logic       pd_dir
);

  localparam int MAXP01 =
    (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int MAXP =
    (MAXP01 > HOLD_CYCLES) ? MAXP01 : HOLD_CYCLES;
  localparam int CW = (MAXP > 1) ? $clog2(MAXP) : 1;

  localparam logic [CW-1:0] L_SETUP  = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] L_STROBE = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] L_HOLD   = CW'(HOLD_CYCLES - 1);

  state_t        r_state;
  state_t        w_ns;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_load;
  logic          r_write;
  logic [7:0]    r_addr;
  logic [7:0]    r_data;
  logic [7:0]    r_rdata;

  logic          w_acc;
  logic          w_wr;
  logic [7:0]    w_addr;
  logic [7:0]    w_data;
  logic          w_cnt_done;
  logic          w_drive;

  logic          w_pard_n;
  logic          w_pawr_n;
  logic          w_lvl_pa;
  logic          w_lvl_pd;
  logic          w_pa_dir;
  logic          w_pd_dir;
  logic [7:0]    w_pa_out;
  logic [7:0]    w_pd_out;
  logic          w_rsp_valid;
  logic [7:0]    w_rsp_data;

  logic          w_unused;
  assign w_unused = ^pa_in;

  assign req_ready  = (r_state == ST_IDLE);
  assign w_acc      = req_valid && req_ready;
  assign w_cnt_done = (r_cnt == '0);

  // Outputs are registered from the next state, so the request fields
  // must come straight from the ports on the accept edge.
  assign w_wr   = w_acc ? req_write : r_write;
  assign w_addr = w_acc ? req_addr  : r_addr;
  assign w_data = w_acc ? req_data  : r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_ns;
      if (w_ns != r_state)
        r_cnt <= w_load;
      else if (!w_cnt_done)
        r_cnt <= r_cnt - 1'b1;
    end
  end

  always_comb begin
    w_ns = r_state;
    unique case (r_state)
      ST_IDLE:     if (req_valid) w_ns = ST_TURN_ON;
      ST_TURN_ON:  w_ns = ST_SETUP;
      ST_SETUP:    if (w_cnt_done) w_ns = ST_STROBE;
      ST_STROBE:   if (w_cnt_done) w_ns = ST_HOLD;
      ST_HOLD:     if (w_cnt_done) w_ns = ST_TURN_OFF;
      ST_TURN_OFF: w_ns = ST_IDLE;
      default:     w_ns = ST_IDLE;
    endcase
  end

  always_comb begin
    w_load = '0;
    unique case (w_ns)
      ST_SETUP:  w_load = L_SETUP;
      ST_STROBE: w_load = L_STROBE;
      ST_HOLD:   w_load = L_HOLD;
      default:   w_load = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_write <= 1'b0;
      r_addr  <= 8'h00;
      r_data  <= 8'h00;
      r_rdata <= 8'h00;
    end else begin
      if (w_acc) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_data  <= req_data;
      end
      // pard_n is still low on the edge ending the last strobe cycle.
      if (r_state == ST_STROBE && w_cnt_done && !r_write)
        r_rdata <= pd_in;
    end
  end

  // FPGA pins drive only inside SETUP..HOLD; the level shifters
  // bracket that window by one cycle on each side.
  assign w_drive = (w_ns == ST_SETUP) || (w_ns == ST_STROBE) ||
                   (w_ns == ST_HOLD);

  always_comb begin
    w_pard_n    = 1'b1;
    w_pawr_n    = 1'b1;
    w_lvl_pa    = LVL_DIR_INPUT;
    w_lvl_pd    = LVL_DIR_INPUT;
    w_pa_dir    = DIR_INPUT;
    w_pd_dir    = DIR_INPUT;
    w_pa_out    = 8'h00;
    w_pd_out    = 8'h00;
    w_rsp_valid = 1'b0;
    w_rsp_data  = 8'h00;
    if (w_ns != ST_IDLE) begin
      w_lvl_pa = LVL_DIR_OUTPUT;
      w_pa_out = w_addr;
      if (w_wr) begin
        w_lvl_pd = LVL_DIR_OUTPUT;
        w_pd_out = w_data;
      end
    end
    if (w_drive) begin
      w_pa_dir = DIR_OUTPUT;
      if (w_wr) w_pd_dir = DIR_OUTPUT;
    end
    if (w_ns == ST_STROBE) begin
      if (w_wr) w_pawr_n = 1'b0;
      else      w_pard_n = 1'b0;
    end
    if (w_ns == ST_TURN_OFF) begin
      w_rsp_valid = 1'b1;
      if (!w_wr) w_rsp_data = r_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pard_n     <= 1'b1;
      pawr_n     <= 1'b1;
      lvl_pa_dir <= LVL_DIR_INPUT;
      lvl_pd_dir <= LVL_DIR_INPUT;
      pa_dir     <= DIR_INPUT;
      pd_dir     <= DIR_INPUT;
      pa_out     <= 8'h00;
      pd_out     <= 8'h00;
      rsp_valid  <= 1'b0;
      rsp_data   <= 8'h00;
    end else begin
      pard_n     <= w_pard_n;
      pawr_n     <= w_pawr_n;
      lvl_pa_dir <= w_lvl_pa;
      lvl_pd_dir <= w_lvl_pd;
      pa_dir     <= w_pa_dir;
      pd_dir     <= w_pd_dir;
      pa_out     <= w_pa_out;
      pd_out     <= w_pd_out;
      rsp_valid  <= w_rsp_valid;
      rsp_data   <= w_rsp_data;
    end
  end

endmodule

// File: tb/tb_bbus_master.sv
// Self-checking bench for bbus_master.
// Scoreboard of accepted requests checked against pins and responses.
module tb_bbus_master;
  import bbus_defs::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       req_valid, req_ready, req_write;
  logic [7:0] req_addr, req_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       pard_n, pawr_n;
  logic       lvl_pa_dir, lvl_pd_dir, pa_dir, pd_dir;
  logic [7:0] pa_in, pa_out, pd_in, pd_out;

  assign pa_in = 8'h00;
  assign pd_in = pard_n ? 8'hFF : 8'hA5;

  bbus_master u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .pard_n(pard_n), .pawr_n(pawr_n),
    .lvl_pa_dir(lvl_pa_dir), .pa_in(pa_in),
    .pa_out(pa_out), .pa_dir(pa_dir),
    .lvl_pd_dir(lvl_pd_dir), .pd_in(pd_in),
    .pd_out(pd_out), .pd_dir(pd_dir)
  );

  logic       b_req_valid, b_req_ready;
  logic       b_rsp_valid;
  logic [7:0] b_rsp_data;
  logic       b_pard_n, b_pawr_n;
  logic       b_lvl_pa, b_lvl_pd, b_pa_dir, b_pd_dir;
  logic [7:0] b_pa_out, b_pd_out;
  logic [7:0] b_zero;
  assign b_zero = 8'h00;

  bbus_master #(
    .SETUP_CYCLES(3), .STROBE_CYCLES(4), .HOLD_CYCLES(2)
  ) u_dut2 (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_write(1'b1), .req_addr(8'h30),
    .req_data(8'hC3),
    .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data),
    .pard_n(b_pard_n), .pawr_n(b_pawr_n),
    .lvl_pa_dir(b_lvl_pa), .pa_in(b_zero),
    .pa_out(b_pa_out), .pa_dir(b_pa_dir),
    .lvl_pd_dir(b_lvl_pd), .pd_in(b_zero),
    .pd_out(b_pd_out), .pd_dir(b_pd_dir)
  );

  typedef struct {
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] rsp;
    int         acc;
  } exp_t;

  exp_t sbq[$];
  int   acc_log[$];
  int   rsp_log[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   exp_strb = 2;
  int   exp_lat = 6;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!rst && req_valid && req_ready) begin
      sbq.push_back('{req_write, req_addr, req_data,
                      (req_write ? 8'h00 : 8'hA5), cyc});
      acc_log.push_back(cyc);
    end
  end

  int   lenw = 0;
  int   lenr = 0;
  logic p_pa_dir = 1'b0;
  logic p_pd_dir = 1'b0;
  logic p_lvl_pa = 1'b0;
  logic p_lvl_pd = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      lenw = 0;
      lenr = 0;
    end else begin
      check("inv_pa", 32'(pa_dir == DIR_OUTPUT &&
            lvl_pa_dir != LVL_DIR_OUTPUT), 0);
      check("inv_pd", 32'(pd_dir == DIR_OUTPUT &&
            lvl_pd_dir != LVL_DIR_OUTPUT), 0);
      check("one_strobe", 32'(!pard_n && !pawr_n), 0);
      if (p_pa_dir == DIR_INPUT && pa_dir == DIR_OUTPUT)
        check("lvl_pa_before", 32'(p_lvl_pa), 32'(LVL_DIR_OUTPUT));
      if (p_pa_dir == DIR_OUTPUT && pa_dir == DIR_INPUT)
        check("lvl_pa_after", 32'(lvl_pa_dir), 32'(LVL_DIR_OUTPUT));
      if (p_pd_dir == DIR_INPUT && pd_dir == DIR_OUTPUT)
        check("lvl_pd_before", 32'(p_lvl_pd), 32'(LVL_DIR_OUTPUT));
      if (p_pd_dir == DIR_OUTPUT && pd_dir == DIR_INPUT)
        check("lvl_pd_after", 32'(lvl_pd_dir), 32'(LVL_DIR_OUTPUT));
      if (sbq.size() > 0) begin
        if (pa_dir == DIR_OUTPUT) begin
          check("pa_out", 32'(pa_out), 32'(sbq[0].a));
          if (sbq[0].w) begin
            check("pd_out", 32'(pd_out), 32'(sbq[0].d));
            check("pd_dir_wr", 32'(pd_dir), 32'(DIR_OUTPUT));
          end
        end
        if (!sbq[0].w)
          check("pd_dir_rd", 32'(pd_dir), 32'(DIR_INPUT));
      end
      if (!pawr_n) begin
        lenw++;
        if (sbq.size() > 0) check("wr_kind", 32'(sbq[0].w), 1);
      end else if (lenw != 0) begin
        check("wr_len", lenw, exp_strb);
        lenw = 0;
      end
      if (!pard_n) begin
        lenr++;
        if (sbq.size() > 0) check("rd_kind", 32'(sbq[0].w), 0);
      end else if (lenr != 0) begin
        check("rd_len", lenr, exp_strb);
        lenr = 0;
      end
      if (rsp_valid) begin
        if (sbq.size() == 0) begin
          check("rsp_unexp", 1, 0);
        end else begin
          e = sbq.pop_front();
          check("rsp_data", 32'(rsp_data), 32'(e.rsp));
          check("rsp_lat", cyc - e.acc + 1, exp_lat);
          rsp_log.push_back(cyc);
        end
      end
    end
    p_pa_dir = pa_dir;
    p_pd_dir = pd_dir;
    p_lvl_pa = lvl_pa_dir;
    p_lvl_pd = lvl_pd_dir;
  end

  task automatic chk_idle(input string tag);
    check({tag, "_pard"}, 32'(pard_n), 1);
    check({tag, "_pawr"}, 32'(pawr_n), 1);
    check({tag, "_lpa"}, 32'(lvl_pa_dir), 32'(LVL_DIR_INPUT));
    check({tag, "_lpd"}, 32'(lvl_pd_dir), 32'(LVL_DIR_INPUT));
    check({tag, "_padir"}, 32'(pa_dir), 32'(DIR_INPUT));
    check({tag, "_pddir"}, 32'(pd_dir), 32'(DIR_INPUT));
    check({tag, "_paout"}, 32'(pa_out), 0);
    check({tag, "_pdout"}, 32'(pd_out), 0);
    check({tag, "_rspv"}, 32'(rsp_valid), 0);
    check({tag, "_rspd"}, 32'(rsp_data), 0);
    check({tag, "_rdy"}, 32'(req_ready), 1);
  endtask

  task automatic do_req(input logic w, input logic [7:0] a,
                        input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_data  = d;
    while (!req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("req_timeout", 1, 0);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sbq.size() == 0 && req_ready) && n < 40);
    if (n >= 40) check("idle_timeout", 1, 0);
  endtask

  initial begin
    int n, lows, got;
    rst = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr = 8'h00;
    req_data = 8'h00;
    b_req_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle("rst");
    @(posedge clk);
    #1 rst = 1'b0;

    do_req(1'b1, 8'h18, 8'h5A);
    wait_idle();
    do_req(1'b0, 8'h3F, 8'h00);
    wait_idle();

    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 8'h21;
    req_data  = 8'h77;
    @(posedge clk);
    #1;
    req_write = 1'b0;
    req_addr  = 8'h22;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 40);
    if (!req_ready) check("b2b_timeout", 1, 0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_idle();
    check("b2b_acc_gap",
          acc_log[acc_log.size()-1] - acc_log[acc_log.size()-2], 7);
    check("b2b_rsp_gap",
          rsp_log[rsp_log.size()-1] - rsp_log[rsp_log.size()-2], 7);

    do_req(1'b1, 8'h40, 8'h11);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pawr_n && n < 40);
    if (pawr_n) check("strb_timeout", 1, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk_idle("midrst");
    sbq.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    check("midrst_ready", 32'(req_ready), 1);

    @(negedge clk);
    check("b_ready", 32'(b_req_ready), 1);
    b_req_valid = 1'b1;
    @(posedge clk);
    #1 b_req_valid = 1'b0;
    lows = 0;
    got = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (!b_pawr_n) begin
        lows++;
        check("b_pa_out", 32'(b_pa_out), 32'h30);
        check("b_pd_out", 32'(b_pd_out), 32'hC3);
      end
      check("b_pard", 32'(b_pard_n), 1);
      if (b_rsp_valid) begin
        check("b_lat", k, 11);
        check("b_rspd", 32'(b_rsp_data), 0);
        got = 1;
        break;
      end
    end
    if (got == 0) check("b_timeout", 1, 0);
    check("b_strb_len", lows, 4);

    check("sb_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
